// File: rtl/mem_arbiter.sv
// Byte-serial arbiter sharing one RAM/IO port between instruction fetches and data loads/stores.
// Optional MEM_ARB_ROUND_ROBIN_EN: alternate grants when both sides wait in IDLE (default: data first).
module mem_arbiter #(
  parameter int         ADDR_WIDTH   = 32,
  parameter logic [1:0] IO_ADDR_BITS = 2'b11
) (
  input  logic                  clockIn,
  input  logic                  resetIn,
  input  logic                  instrReq,
  input  logic [ADDR_WIDTH-1:0] instrAddr,
  output logic                  instrValid,
  output logic [31:0]           instrOut,
  input  logic                  flushIn,
  input  logic [1:0]            accessType,
  input  logic                  readWriteIn,
  input  logic [ADDR_WIDTH-1:0] dataAddr,
  input  logic [31:0]           dataIn,
  output logic                  dataValid,
  output logic [31:0]           dataOut,
  output logic                  dataWriteSuc,
  input  logic [7:0]            memIn,
  output logic [7:0]            memOut,
  output logic [ADDR_WIDTH-1:0] memAddr,
  output logic                  memWrite,
  input  logic                  ioBufferFull
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  function automatic logic [2:0] byte_count(input logic [1:0] t);
    case (t)
      2'b01:   byte_count = 3'd1;
      2'b10:   byte_count = 3'd2;
      default: byte_count = 3'd4;
    endcase
  endfunction

  function automatic logic is_io(input logic [ADDR_WIDTH-1:0] a);
    is_io = (a[17:16] == IO_ADDR_BITS);
  endfunction

  state_t                state_q, state_d;
  logic                  pend_q, pend_d;
  logic [1:0]            lat_type_q, lat_type_d;
  logic                  lat_rw_q, lat_rw_d;
  logic [ADDR_WIDTH-1:0] lat_addr_q, lat_addr_d;
  logic [31:0]           lat_data_q, lat_data_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           word_q, word_d;
  logic [2:0]            n_q, n_d;
  logic [2:0]            cnt_q, cnt_d;
  logic                  instr_side_q, instr_side_d;
  logic                  instr_valid_q, instr_valid_d;
  logic [31:0]           instr_out_q, instr_out_d;
  logic                  data_valid_q, data_valid_d;
  logic [31:0]           data_out_q, data_out_d;
  logic                  wr_suc_q, wr_suc_d;
  logic [7:0]            mem_out_q, mem_out_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                  mem_write_q, mem_write_d;

  // Effective data request: the latched one wins, otherwise a request arriving this cycle.
  logic                  new_req;
  logic                  data_avail, instr_avail, prefer_data;
  logic                  grant_data, grant_instr;
  logic [1:0]            req_type;
  logic                  req_rw;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_data;

  assign new_req     = (accessType != 2'b00);
  assign data_avail  = pend_q | new_req;
  assign instr_avail = instrReq & ~flushIn;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_instr_q, last_instr_d;
  assign prefer_data = last_instr_q;
`else
  assign prefer_data = 1'b1;
`endif

  assign grant_data  = data_avail & (prefer_data | ~instr_avail);
  assign grant_instr = instr_avail & ~grant_data;

  always_comb begin
    if (pend_q) begin
      req_type = lat_type_q;
      req_rw   = lat_rw_q;
      req_addr = lat_addr_q;
      req_data = lat_data_q;
    end else begin
      req_type = accessType;
      req_rw   = readWriteIn;
      req_addr = dataAddr;
      req_data = dataIn;
    end
  end

  // Byte lanes: read capture merges memIn into lane cnt-1; writes pick lane cnt.
  genvar gi;
  logic [31:0] merged_word;
  logic [7:0]  wr_bytes [4];
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign merged_word[gi*8 +: 8] = (cnt_q == 3'(gi + 1)) ? memIn : word_q[gi*8 +: 8];
      assign wr_bytes[gi]           = wdata_q[gi*8 +: 8];
    end
  endgenerate

  logic io_stall;
  assign io_stall = is_io(base_q) & ioBufferFull;

  always_comb begin
    state_d       = state_q;
    pend_d        = pend_q;
    lat_type_d    = lat_type_q;
    lat_rw_d      = lat_rw_q;
    lat_addr_d    = lat_addr_q;
    lat_data_d    = lat_data_q;
    base_d        = base_q;
    wdata_d       = wdata_q;
    word_d        = word_q;
    n_d           = n_q;
    cnt_d         = cnt_q;
    instr_side_d  = instr_side_q;
    instr_valid_d = 1'b0;
    instr_out_d   = instr_out_q;
    data_valid_d  = 1'b0;
    data_out_d    = data_out_q;
    wr_suc_d      = 1'b0;
    mem_out_d     = mem_out_q;
    mem_addr_d    = mem_addr_q;
    mem_write_d   = mem_write_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    last_instr_d  = last_instr_q;
`endif

    // A request while one is already pending is dropped.
    if (new_req && !pend_q) begin
      lat_type_d = accessType;
      lat_rw_d   = readWriteIn;
      lat_addr_d = dataAddr;
      lat_data_d = dataIn;
      pend_d     = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (grant_data) begin
          pend_d       = 1'b0;
          base_d       = req_addr;
          wdata_d      = req_data;
          word_d       = 32'd0;
          n_d          = byte_count(req_type);
          instr_side_d = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          last_instr_d = 1'b0;
`endif
          if (req_rw) begin
            state_d     = READ;
            mem_addr_d  = req_addr;
            mem_write_d = 1'b0;
            cnt_d       = 3'd1;
          end else if (is_io(req_addr) && ioBufferFull) begin
            state_d     = WRITE;
            mem_write_d = 1'b0;
            cnt_d       = 3'd0;
          end else begin
            state_d     = WRITE;
            mem_addr_d  = req_addr;
            mem_out_d   = req_data[7:0];
            mem_write_d = 1'b1;
            cnt_d       = 3'd1;
          end
        end else if (grant_instr) begin
          state_d      = READ;
          base_d       = instrAddr;
          word_d       = 32'd0;
          n_d          = 3'd4;
          instr_side_d = 1'b1;
          mem_addr_d   = instrAddr;
          mem_write_d  = 1'b0;
          cnt_d        = 3'd1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          last_instr_d = 1'b1;
`endif
        end
      end

      READ: begin
        if (instr_side_q && flushIn) begin
          state_d     = IDLE;
          mem_write_d = 1'b0;
        end else begin
          word_d = merged_word;
          if (cnt_q == n_q) begin
            state_d = DONE;
            if (instr_side_q) begin
              instr_valid_d = 1'b1;
              instr_out_d   = merged_word;
            end else begin
              data_valid_d = 1'b1;
              data_out_d   = merged_word;
            end
          end else begin
            mem_addr_d = base_q + ADDR_WIDTH'(cnt_q);
            cnt_d      = cnt_q + 3'd1;
          end
        end
      end

      WRITE: begin
        if (cnt_q == n_q) begin
          state_d     = DONE;
          mem_write_d = 1'b0;
          wr_suc_d    = 1'b1;
        end else if (io_stall) begin
          mem_write_d = 1'b0;
        end else begin
          mem_addr_d  = base_q + ADDR_WIDTH'(cnt_q);
          mem_out_d   = wr_bytes[cnt_q[1:0]];
          mem_write_d = 1'b1;
          cnt_d       = cnt_q + 3'd1;
        end
      end

      default: begin
        state_d     = IDLE;
        mem_write_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clockIn) begin
    if (resetIn) begin
      state_q       <= IDLE;
      pend_q        <= 1'b0;
      lat_type_q    <= 2'b00;
      lat_rw_q      <= 1'b0;
      lat_addr_q    <= '0;
      lat_data_q    <= 32'd0;
      base_q        <= '0;
      wdata_q       <= 32'd0;
      word_q        <= 32'd0;
      n_q           <= 3'd0;
      cnt_q         <= 3'd0;
      instr_side_q  <= 1'b0;
      instr_valid_q <= 1'b0;
      instr_out_q   <= 32'd0;
      data_valid_q  <= 1'b0;
      data_out_q    <= 32'd0;
      wr_suc_q      <= 1'b0;
      mem_out_q     <= 8'd0;
      mem_addr_q    <= '0;
      mem_write_q   <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_instr_q  <= 1'b1;
`endif
    end else begin
      state_q       <= state_d;
      pend_q        <= pend_d;
      lat_type_q    <= lat_type_d;
      lat_rw_q      <= lat_rw_d;
      lat_addr_q    <= lat_addr_d;
      lat_data_q    <= lat_data_d;
      base_q        <= base_d;
      wdata_q       <= wdata_d;
      word_q        <= word_d;
      n_q           <= n_d;
      cnt_q         <= cnt_d;
      instr_side_q  <= instr_side_d;
      instr_valid_q <= instr_valid_d;
      instr_out_q   <= instr_out_d;
      data_valid_q  <= data_valid_d;
      data_out_q    <= data_out_d;
      wr_suc_q      <= wr_suc_d;
      mem_out_q     <= mem_out_d;
      mem_addr_q    <= mem_addr_d;
      mem_write_q   <= mem_write_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_instr_q  <= last_instr_d;
`endif
    end
  end

  assign instrValid   = instr_valid_q;
  assign instrOut     = instr_out_q;
  assign dataValid    = data_valid_q;
  assign dataOut      = data_out_q;
  assign dataWriteSuc = wr_suc_q;
  assign memOut       = mem_out_q;
  assign memAddr      = mem_addr_q;
  assign memWrite     = mem_write_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: per-scenario tasks plus a negedge scoreboard monitor
// for byte writes, read completions and write completions.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        resetIn;
  logic        instrReq;
  logic [31:0] instrAddr;
  logic        instrValid;
  logic [31:0] instrOut;
  logic        flushIn;
  logic [1:0]  accessType;
  logic        readWriteIn;
  logic [31:0] dataAddr;
  logic [31:0] dataIn;
  logic        dataValid;
  logic [31:0] dataOut;
  logic        dataWriteSuc;
  logic [7:0]  memIn;
  logic [7:0]  memOut;
  logic [31:0] memAddr;
  logic        memWrite;
  logic        ioBufferFull;

  int checks = 0;
  int errors = 0;

  logic [7:0]  ram [0:4095];
  logic [39:0] exp_wr[$];
  logic [31:0] exp_data[$];
  logic [31:0] exp_instr[$];
  int          exp_suc = 0;

  always #5 clk = ~clk;

  // RAM read data is valid in the cycle after the address edge.
  assign memIn = ram[memAddr[11:0]];

  mem_arbiter dut (
    .clockIn(clk), .resetIn(resetIn),
    .instrReq(instrReq), .instrAddr(instrAddr), .instrValid(instrValid), .instrOut(instrOut),
    .flushIn(flushIn),
    .accessType(accessType), .readWriteIn(readWriteIn), .dataAddr(dataAddr), .dataIn(dataIn),
    .dataValid(dataValid), .dataOut(dataOut), .dataWriteSuc(dataWriteSuc),
    .memIn(memIn), .memOut(memOut), .memAddr(memAddr), .memWrite(memWrite),
    .ioBufferFull(ioBufferFull)
  );

  always @(negedge clk) begin
    if (memWrite) begin
      checks++;
      if (exp_wr.size() == 0) begin
        errors++;
        $display("FAIL wr_unexpected got addr=%h byte=%h required none", memAddr, memOut);
      end else begin
        logic [39:0] w;
        w = exp_wr.pop_front();
        if ({memAddr, memOut} !== w) begin
          errors++;
          $display("FAIL wr_byte got %h/%h required %h/%h", memAddr, memOut, w[39:8], w[7:0]);
        end else $display("txn write addr=%h byte=%h", memAddr, memOut);
      end
    end
    if (dataValid) begin
      checks++;
      if (exp_data.size() == 0) begin
        errors++;
        $display("FAIL data_unexpected got %h required none", dataOut);
      end else begin
        logic [31:0] d;
        d = exp_data.pop_front();
        if (dataOut !== d) begin
          errors++;
          $display("FAIL data_read got %h required %h", dataOut, d);
        end else $display("txn data read %h", dataOut);
      end
    end
    if (instrValid) begin
      checks++;
      if (exp_instr.size() == 0) begin
        errors++;
        $display("FAIL instr_unexpected got %h required none", instrOut);
      end else begin
        logic [31:0] d;
        d = exp_instr.pop_front();
        if (instrOut !== d) begin
          errors++;
          $display("FAIL instr_read got %h required %h", instrOut, d);
        end else $display("txn instr fetch %h", instrOut);
      end
    end
    if (dataWriteSuc) begin
      checks++;
      if (exp_suc <= 0) begin
        errors++;
        $display("FAIL suc_unexpected got 1 required 0");
      end else begin
        exp_suc--;
        $display("txn write complete");
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic data_req(input logic [1:0] t, input logic rw, input logic [31:0] a, input logic [31:0] d);
    accessType  = t;
    readWriteIn = rw;
    dataAddr    = a;
    dataIn      = d;
  endtask

  task automatic test_reset();
    resetIn = 1'b1;
    tick();
    tick();
    checks++;
    if ({memWrite, instrValid, dataValid, dataWriteSuc} !== 4'b0 || memAddr !== 32'h0 ||
        memOut !== 8'h0 || dataOut !== 32'h0 || instrOut !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs got wr=%b iv=%b dv=%b suc=%b addr=%h out=%h do=%h io=%h required all 0",
               memWrite, instrValid, dataValid, dataWriteSuc, memAddr, memOut, dataOut, instrOut);
    end
    resetIn = 1'b0;
    tick();
  endtask

  task automatic test_word_fetch();
    ram[12'h100] = 8'h13; ram[12'h101] = 8'h05; ram[12'h102] = 8'h00; ram[12'h103] = 8'h00;
    exp_instr.push_back(32'h00000513);
    instrReq  = 1'b1;
    instrAddr = 32'h100;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (memAddr !== 32'h100 + 32'(k) || memWrite !== 1'b0 || instrValid !== 1'b0) begin
        errors++;
        $display("FAIL fetch_addr%0d got %h wr=%b iv=%b required %h wr=0 iv=0",
                 k, memAddr, memWrite, instrValid, 32'h100 + 32'(k));
      end
    end
    tick();
    checks++;
    if (instrValid !== 1'b1) begin
      errors++;
      $display("FAIL fetch_latency got instrValid=%b required 1", instrValid);
    end
    instrReq = 1'b0;
    tick();
    checks++;
    if (instrValid !== 1'b0 || instrOut !== 32'h00000513) begin
      errors++;
      $display("FAIL fetch_pulse got iv=%b io=%h required 0/00000513", instrValid, instrOut);
    end
    tick();
  endtask

  task automatic test_byte_read();
    ram[12'h001] = 8'hAB;
    ram[12'h002] = 8'hFF;
    exp_data.push_back(32'h000000AB);
    data_req(2'b01, 1'b1, 32'h2001, 32'h0);
    tick();
    data_req(2'b00, 1'b0, 32'h0, 32'h0);
    checks++;
    if (memAddr !== 32'h2001 || memWrite !== 1'b0) begin
      errors++;
      $display("FAIL byte_read_addr got %h wr=%b required 00002001 wr=0", memAddr, memWrite);
    end
    tick();
    checks++;
    if (dataValid !== 1'b1) begin
      errors++;
      $display("FAIL byte_read_latency got dataValid=%b required 1", dataValid);
    end
    tick();
    tick();
  endtask

  task automatic test_half_read_wrap();
    ram[12'hFFF] = 8'h11;
    ram[12'h000] = 8'h22;
    exp_data.push_back(32'h00002211);
    data_req(2'b10, 1'b1, 32'hFFFF_FFFF, 32'h0);
    tick();
    data_req(2'b00, 1'b0, 32'h0, 32'h0);
    checks++;
    if (memAddr !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL wrap_addr0 got %h required ffffffff", memAddr);
    end
    tick();
    checks++;
    if (memAddr !== 32'h0000_0000) begin
      errors++;
      $display("FAIL wrap_addr1 got %h required 00000000", memAddr);
    end
    tick();
    tick();
    tick();
  endtask

  task automatic test_half_write();
    exp_wr.push_back({32'h30, 8'hCD});
    exp_wr.push_back({32'h31, 8'hAB});
    exp_suc++;
    data_req(2'b10, 1'b0, 32'h30, 32'h1234ABCD);
    tick();
    data_req(2'b00, 1'b0, 32'h0, 32'h0);
    tick();
    tick();
    checks++;
    if (memWrite !== 1'b0 || dataWriteSuc !== 1'b1) begin
      errors++;
      $display("FAIL half_write_end got wr=%b suc=%b required 0/1", memWrite, dataWriteSuc);
    end
    tick();
    tick();
  endtask

  task automatic test_io_stall();
    exp_wr.push_back({32'h30000, 8'hAA});
    exp_wr.push_back({32'h30001, 8'hBB});
    exp_wr.push_back({32'h30002, 8'hCC});
    exp_wr.push_back({32'h30003, 8'hDD});
    exp_suc++;
    data_req(2'b11, 1'b0, 32'h30000, 32'hDDCCBBAA);
    tick();
    data_req(2'b00, 1'b0, 32'h0, 32'h0);
    ioBufferFull = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (memWrite !== 1'b0 || memAddr !== 32'h30000) begin
        errors++;
        $display("FAIL io_stall%0d got wr=%b addr=%h required 0/00030000", k, memWrite, memAddr);
      end
    end
    ioBufferFull = 1'b0;
    tick();
    checks++;
    if (memWrite !== 1'b1 || memAddr !== 32'h30001) begin
      errors++;
      $display("FAIL io_resume got wr=%b addr=%h required 1/00030001", memWrite, memAddr);
    end
    tick();
    tick();
    tick();
    checks++;
    if (dataWriteSuc !== 1'b1) begin
      errors++;
      $display("FAIL io_suc got %b required 1", dataWriteSuc);
    end
    tick();
    tick();
  endtask

  task automatic test_arb_flush();
    ram[12'h300] = 8'h77;
    ram[12'h400] = 8'h99;
    exp_data.push_back(32'h00000077);
    instrReq  = 1'b1;
    instrAddr = 32'h200;
    data_req(2'b01, 1'b1, 32'h300, 32'h0);
    tick();
    data_req(2'b00, 1'b0, 32'h0, 32'h0);
    checks++;
    if (memAddr !== 32'h300) begin
      errors++;
      $display("FAIL arb_data_first got %h required 00000300", memAddr);
    end
    tick();
    tick();
    tick();
    checks++;
    if (memAddr !== 32'h200) begin
      errors++;
      $display("FAIL arb_instr_next got %h required 00000200", memAddr);
    end
    tick();
    tick();
    flushIn = 1'b1;
    exp_data.push_back(32'h00000099);
    data_req(2'b01, 1'b1, 32'h400, 32'h0);
    tick();
    flushIn  = 1'b0;
    instrReq = 1'b0;
    data_req(2'b00, 1'b0, 32'h0, 32'h0);
    checks++;
    if (instrValid !== 1'b0 || memWrite !== 1'b0) begin
      errors++;
      $display("FAIL flush_abort got iv=%b wr=%b required 0/0", instrValid, memWrite);
    end
    tick();
    checks++;
    if (memAddr !== 32'h400) begin
      errors++;
      $display("FAIL flush_latched_req got %h required 00000400", memAddr);
    end
    tick();
    tick();
    tick();
  endtask

  task automatic test_reset_mid_write();
    exp_wr.push_back({32'h40, 8'h11});
    exp_wr.push_back({32'h41, 8'h22});
    data_req(2'b11, 1'b0, 32'h40, 32'h44332211);
    tick();
    data_req(2'b00, 1'b0, 32'h0, 32'h0);
    tick();
    resetIn = 1'b1;
    tick();
    resetIn = 1'b0;
    checks++;
    if (memWrite !== 1'b0 || dataWriteSuc !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_write got wr=%b suc=%b required 0/0", memWrite, dataWriteSuc);
    end
    tick();
    ram[12'h040] = 8'h5A;
    exp_data.push_back(32'h0000005A);
    data_req(2'b01, 1'b1, 32'h40, 32'h0);
    tick();
    data_req(2'b00, 1'b0, 32'h0, 32'h0);
    checks++;
    if (memAddr !== 32'h40) begin
      errors++;
      $display("FAIL post_reset_addr got %h required 00000040", memAddr);
    end
    tick();
    tick();
    tick();
  endtask

`ifdef MEM_ARB_ROUND_ROBIN_EN
  task automatic test_round_robin();
    resetIn = 1'b1;
    tick();
    resetIn = 1'b0;
    tick();
    ram[12'h600] = 8'h66; ram[12'h610] = 8'h6A;
    ram[12'h500] = 8'h01; ram[12'h501] = 8'h02; ram[12'h502] = 8'h03; ram[12'h503] = 8'h04;
    exp_data.push_back(32'h00000066);
    exp_instr.push_back(32'h04030201);
    exp_data.push_back(32'h0000006A);
    instrReq  = 1'b1;
    instrAddr = 32'h500;
    data_req(2'b01, 1'b1, 32'h600, 32'h0);
    tick();
    data_req(2'b01, 1'b1, 32'h610, 32'h0);
    checks++;
    if (memAddr !== 32'h600) begin
      errors++;
      $display("FAIL rr_first_data got %h required 00000600", memAddr);
    end
    tick();
    data_req(2'b00, 1'b0, 32'h0, 32'h0);
    tick();
    tick();
    checks++;
    if (memAddr !== 32'h500) begin
      errors++;
      $display("FAIL rr_then_instr got %h required 00000500", memAddr);
    end
    for (int k = 0; k < 4; k++) tick();
    instrReq = 1'b0;
    tick();
    tick();
    checks++;
    if (memAddr !== 32'h610) begin
      errors++;
      $display("FAIL rr_then_data got %h required 00000610", memAddr);
    end
    tick();
    tick();
    tick();
  endtask
`endif

  initial begin
    resetIn = 1'b1; instrReq = 1'b0; instrAddr = 32'h0; flushIn = 1'b0;
    accessType = 2'b00; readWriteIn = 1'b0; dataAddr = 32'h0; dataIn = 32'h0;
    ioBufferFull = 1'b0;
    for (int i = 0; i < 4096; i++) ram[i] = 8'h00;

    test_reset();
    test_word_fetch();
    test_byte_read();
    test_half_read_wrap();
    test_half_write();
    test_io_stall();
    test_arb_flush();
    test_reset_mid_write();
`ifdef MEM_ARB_ROUND_ROBIN_EN
    test_round_robin();
`endif

    checks++;
    if (exp_wr.size() != 0 || exp_data.size() != 0 || exp_instr.size() != 0 || exp_suc != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got wr=%0d data=%0d instr=%0d suc=%0d outstanding required 0",
               exp_wr.size(), exp_data.size(), exp_instr.size(), exp_suc);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences and shares the CPU's single byte-wide RAM/IO port between the instruction cache (word fetches) and the load/store path (byte, half-word and word accesses).
- Serialises each word request into little-endian byte transfers and reassembles read data.
- Stalls IO writes while the IO buffer is full.
- Sits between the ICache/DCache and the top-level memory pins.

Parameters:
- ADDR_WIDTH, 32, width of all addresses; byte addresses wrap modulo 2^ADDR_WIDTH.
- IO_ADDR_BITS, 2'b11, value of addr[17:16] that marks an IO address.

Ports:
- clockIn  input  1  system clock; all state on rising edge.
- resetIn  input  1  synchronous, active-high reset.
- instrReq  input  1  ICache fetch request, level; held until instrValid.
- instrAddr  input  ADDR_WIDTH  fetch address, stable while instrReq is high.
- instrValid  output  1  one-cycle pulse: instrOut holds the fetched word.
- instrOut  output  32  fetched word, little-endian.
- flushIn  input  1  misprediction flush; aborts an in-progress or pending fetch.
- accessType  input  2  DCache request: 00 none, 01 byte, 10 half, 11 word. A non-zero value is a one-cycle pulse.
- readWriteIn  input  1  1 = read, 0 = write; sampled with accessType.
- dataAddr  input  ADDR_WIDTH  data byte address, sampled with accessType.
- dataIn  input  32  write data; the low 8/16/32 bits are used.
- dataValid  output  1  one-cycle pulse: dataOut holds read data.
- dataOut  output  32  read data, zero-extended to 32 bits.
- dataWriteSuc  output  1  one-cycle pulse: write completed.
- memIn  input  8  RAM/IO read byte; valid the cycle after its address edge.
- memOut  output  8  byte to write.
- memAddr  output  ADDR_WIDTH  byte address.
- memWrite  output  1  1 = write memOut at memAddr.
- ioBufferFull  input  1  IO buffer full; IO writes must not issue.

Behaviour:
- Reset (resetIn high at an edge):
  - All outputs go to 0.
  - State returns to IDLE; the pending data latch and the byte counter clear.
  - Reset mid-transfer abandons the transfer with no completion pulse.
- Data request latch:
  - When accessType != 00 at an edge, latch {type, rw, addr, data} and set pend = 1, even while busy.
  - A second request while pend = 1 is a protocol error and is ignored.
- States: IDLE, READ, WRITE, DONE.
  - IDLE: grant in priority order.
    1. Pending data (including a request arriving this same cycle) goes to READ or WRITE and clears pend.
    2. Otherwise, if instrReq && !flushIn, go to READ with n = 4 on the instruction side.
  - Byte count n: 01→1, 10→2, 11→4. The counter runs 0..n-1.
- READ timing. E0 is the grant edge.
  - At edge Ek (k < n), drive memAddr = base + k and memWrite = 0.
  - At edge Ek+1, capture memIn into byte lane k.
  - At edge En, present the full word with the last byte merged directly from memIn. Pulse dataValid or instrValid high for the cycle after En, then go to DONE.
  - Total latency is n cycles from grant to pulse.
- WRITE timing:
  - At edge Ek, drive memAddr = base + k, memOut = byte k, memWrite = 1.
  - At edge En, drive memWrite = 0 and pulse dataWriteSuc, then go to DONE.
- IO stall:
  - If addr[17:16] == IO_ADDR_BITS and ioBufferFull = 1 at the edge where byte k would issue, hold memWrite = 0 and keep k.
  - Retry every cycle until ioBufferFull = 0.
  - IO reads are not stalled.
- DONE: lasts one cycle; clears pulses and memWrite, then returns to IDLE. The next grant is at the following edge.
  - An instruction re-grant therefore never overlaps instrValid.
- flushIn:
  - During an instruction READ: return to IDLE next edge with no instrValid and memWrite = 0.
  - Never aborts data transfers.
  - A data request in the same cycle as flushIn is still latched.
- Address arithmetic: base + k wraps at 2^ADDR_WIDTH, e.g. 0xFFFFFFFF + 1 = 0x00000000.
- Unused bytes of dataOut are 0. instrOut holds its value until the next fetch completes.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined: a 1-bit lastGrant flag. When data and instruction requests are both pending in IDLE, grant the side not served last; reset sets lastGrant = instr, so data wins first.
- Undefined: strict data-over-instruction priority as above.

Test Plan:
- Word fetch: instrReq = 1, instrAddr = 0x100, RAM holds 0x13 0x05 0x00 0x00 → memAddr 0x100..0x103 on 4 consecutive cycles; instrValid pulses once 4 cycles after grant with instrOut = 0x00000513.
- Byte read: accessType = 01 read at 0x2001, byte 0xAB → single memAddr 0x2001; dataValid pulse 1 cycle after grant, dataOut = 0x000000AB.
- Half-word write: accessType = 10, write dataIn = 0x1234ABCD to 0x30 → (0x30, 0xCD, wr = 1), (0x31, 0xAB, wr = 1); then memWrite = 0 and dataWriteSuc pulse.
- IO stall: word write to 0x30000 with ioBufferFull = 1 for 3 cycles at byte 1 → byte 0 issues; memWrite = 0 and memAddr is not advanced for those 3 cycles; then bytes 1..3 issue and dataWriteSuc pulses.
- Arbitration and flush: instrReq and a data read pulse arrive in the same cycle → data is served first. flushIn asserted on instruction byte 2 → no instrValid, IDLE next edge. With MEM_ARB_ROUND_ROBIN_EN and both requests continuously pending → grants alternate data, instr, data.
- Reset mid-write: resetIn at byte 2 of a word write → next cycle memWrite = 0, no dataWriteSuc, a later request serves normally.
